// File: rtl/hub75_scan_driver_pkg.sv
// Shared constants, field positions and FSM encoding
// for the HUB75 scan driver.
package hub75_scan_driver_pkg;

  localparam int COLS       = 64;
  localparam int ROWS       = 64;
  localparam int SCAN_LINES = ROWS / 2;
  localparam int ADDR_W     = 12;
  localparam int COL_W      = $clog2(COLS);
  localparam int LINE_W     = $clog2(SCAN_LINES);
  localparam int PIX_W      = 24;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } state_t;

endpackage

// File: rtl/hub75_scan_driver_if.sv
// Dual-port framebuffer read bus: the driver issues
// addresses, the memory returns pixels one cycle later.
interface hub75_scan_driver_if;
  import hub75_scan_driver_pkg::*;

  logic [ADDR_W-1:0] addr_top;
  logic [ADDR_W-1:0] addr_bottom;
  logic [PIX_W-1:0]  pix_top;
  logic [PIX_W-1:0]  pix_bottom;

  modport master (
    output addr_top, addr_bottom,
    input  pix_top, pix_bottom
  );

  modport slave (
    input  addr_top, addr_bottom,
    output pix_top, pix_bottom
  );

endinterface

// File: rtl/hub75_scan_driver_pixel_to_1bpp.sv
// Thresholds one RGB888 pixel to a 1-bit-per-channel
// {r,g,b} triple.
module pixel_to_1bpp
  import hub75_scan_driver_pkg::*;
#(
  parameter int THRESH = 128
) (
  input  logic [PIX_W-1:0] pix,
  output logic [2:0]       rgb
);

  localparam logic [8:0] TH = 9'(THRESH);

  assign rgb = {
    {1'b0, pix[R_HI:R_LO]} >= TH,
    {1'b0, pix[G_HI:G_LO]} >= TH,
    {1'b0, pix[B_HI:B_LO]} >= TH
  };

endmodule

// File: rtl/hub75_scan_driver.sv
// Scans a 64x64 framebuffer into a 1/32 HUB75 panel:
// shift two rows per line, latch, then display.
module hub75_scan_driver
  import hub75_scan_driver_pkg::*;
#(
  parameter int THRESH     = 128,
  parameter int LAT_CYCLES = 2,
  parameter int ON_CYCLES  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  hub75_scan_driver_if.master fb,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic              r2,
  output logic              g2,
  output logic              b2,
  output logic              panel_clk,
  output logic              lat,
  output logic              oe_n,
  output logic [LINE_W-1:0] row_sel,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(ON_CYCLES);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] at_q, at_d;
  logic [ADDR_W-1:0] ab_q, ab_d;
  logic [2:0]        rgb1_q, rgb1_d;
  logic [2:0]        rgb2_q, rgb2_d;
  logic [2:0]        px1, px2;
  logic              pclk_q, pclk_d;
  logic              lat_q, lat_d;
  logic              oen_q, oen_d;
  logic              fd_q, fd_d;
  logic [LINE_W-1:0] rs_q, rs_d;

  pixel_to_1bpp #(.THRESH(THRESH)) u_top (
    .pix (fb.pix_top),
    .rgb (px1)
  );

  pixel_to_1bpp #(.THRESH(THRESH)) u_bot (
    .pix (fb.pix_bottom),
    .rgb (px2)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          col_d   = '0;
          phase_d = '0;
        end
      end
      SHIFT: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          col_d = col_q + 1'b1;
          if (col_q == COL_W'(COLS - 1)) begin
            state_d = LATCH;
            cnt_d   = '0;
          end
        end
      end
      LATCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LAT_CYCLES - 1)) begin
          state_d = DISPLAY;
          cnt_d   = '0;
        end
      end
      DISPLAY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
          line_d  = line_q + 1'b1;
          fd_d    = (line_q == LINE_W'(SCAN_LINES - 1));
          state_d = enable ? SHIFT : IDLE;
          col_d   = '0;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Outputs derive from the next state so every pin is a flop
  // that already shows the new phase's value in that phase.
  always_comb begin
    at_d   = at_q;
    ab_d   = ab_q;
    rgb1_d = rgb1_q;
    rgb2_d = rgb2_q;
    rs_d   = rs_q;
    if (state_d == SHIFT && phase_d == 2'd0) begin
      at_d = ADDR_W'({line_d, col_d});
      ab_d = ADDR_W'({1'b1, line_d, col_d});
    end
    if (state_q == SHIFT && phase_q == 2'd1) begin
      rgb1_d = px1;
      rgb2_d = px2;
    end
    if (state_d == LATCH && state_q != LATCH) begin
      rs_d = line_q;
    end
    pclk_d = (state_d == SHIFT) && (phase_d == 2'd3);
    lat_d  = (state_d == LATCH);
    oen_d  = (state_d != DISPLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      at_q    <= '0;
      ab_q    <= '0;
      rgb1_q  <= '0;
      rgb2_q  <= '0;
      pclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oen_q   <= 1'b1;
      rs_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      at_q    <= at_d;
      ab_q    <= ab_d;
      rgb1_q  <= rgb1_d;
      rgb2_q  <= rgb2_d;
      pclk_q  <= pclk_d;
      lat_q   <= lat_d;
      oen_q   <= oen_d;
      rs_q    <= rs_d;
      fd_q    <= fd_d;
    end
  end

  assign fb.addr_top    = at_q;
  assign fb.addr_bottom = ab_q;
  assign {r1, g1, b1}   = rgb1_q;
  assign {r2, g2, b2}   = rgb2_q;
  assign panel_clk      = pclk_q;
  assign lat            = lat_q;
  assign oe_n           = oen_q;
  assign row_sel        = rs_q;
  assign frame_done     = fd_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: memory model, panel-side
// monitor and a line-by-line reference of the scan.
module tb_hub75_scan_driver;

  logic clk;
  logic rst;
  logic enable;
  logic r1, g1, b1, r2, g2, b2;
  logic panel_clk, lat, oe_n, frame_done;
  logic [4:0] row_sel;

  hub75_scan_driver_if fb_if();

  hub75_scan_driver dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fb         (fb_if),
    .r1         (r1),
    .g1         (g1),
    .b1         (b1),
    .r2         (r2),
    .g2         (g2),
    .b2         (b2),
    .panel_clk  (panel_clk),
    .lat        (lat),
    .oe_n       (oe_n),
    .row_sel    (row_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [0:4095];

  always @(posedge clk) begin
    fb_if.pix_top    <= mem[fb_if.addr_top];
    fb_if.pix_bottom <= mem[fb_if.addr_bottom];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d",
                 nm, got, exp);
    end
  endtask

  function automatic logic [2:0] thr(input logic [23:0] p);
    return {p[23:16] >= 8'd128,
            p[15:8] >= 8'd128,
            p[7:0] >= 8'd128};
  endfunction

  // Panel-side monitor: rebuilds each shifted line and checks
  // it against the framebuffer at the latch strobe.
  logic [2:0] cap_t [0:63];
  logic [2:0] cap_b [0:63];
  logic [2:0] sav_t [0:31][0:63];
  logic [2:0] sav_b [0:31][0:63];
  int ncol = 0;
  int exp_line = 0;
  int last_line = -1;
  int nlat = 0;
  int lat_cyc = 0;
  int prev_lat_cyc = 0;
  int nfd = 0;
  int fd_cyc = 0;
  bit fd_have = 0;
  int oe_viol = 0;
  logic pclk_p = 0;
  logic lat_p = 0;
  logic fd_p = 0;
  logic [4:0] rs_p = 0;

  always @(negedge clk) begin
    if (rst) begin
      ncol = 0;
      exp_line = 0;
      fd_have = 0;
      nfd = 0;
    end else begin
      if (panel_clk && !pclk_p) begin
        if (ncol < 64) begin
          cap_t[ncol] = {r1, g1, b1};
          cap_b[ncol] = {r2, g2, b2};
          check("addr_top", fb_if.addr_top,
                exp_line * 64 + ncol);
          check("addr_bottom", fb_if.addr_bottom,
                2048 + exp_line * 64 + ncol);
        end
        ncol++;
      end
      if (lat && !lat_p) begin
        int bad;
        bad = 0;
        check("ncols", ncol, 64);
        check("row_sel", row_sel, exp_line);
        for (int c = 0; c < 64; c++) begin
          if (cap_t[c] !== thr(mem[exp_line * 64 + c]))
            bad++;
          if (cap_b[c] !== thr(mem[2048 + exp_line * 64 + c]))
            bad++;
          sav_t[exp_line][c] = cap_t[c];
          sav_b[exp_line][c] = cap_b[c];
        end
        check("rowdata_bad_bits", bad, 0);
        last_line = exp_line;
        exp_line = (exp_line + 1) % 32;
        ncol = 0;
        nlat++;
        prev_lat_cyc = lat_cyc;
        lat_cyc = cyc;
      end
      if (!oe_n && row_sel !== rs_p) oe_viol++;
      if (frame_done) begin
        check("fd_after_line31", last_line, 31);
        check("fd_width", fd_p, 0);
        if (fd_have)
          check("fd_period", cyc - fd_cyc, 16448);
        fd_cyc = cyc;
        fd_have = 1;
        nfd++;
      end
    end
    pclk_p = panel_clk;
    lat_p = lat;
    fd_p = frame_done;
    rs_p = row_sel;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_latch(input int line, input int budget);
    int n0;
    int t;
    bit ok;
    n0 = nlat;
    t = 0;
    ok = 0;
    while (!ok && t < budget) begin
      step();
      t++;
      if (nlat != n0 && last_line == line) ok = 1;
    end
    check($sformatf("latch_line%0d_seen", line), ok, 1);
  endtask

  typedef struct {
    int          col;
    logic [23:0] pt;
    logic [23:0] pb;
    logic [2:0]  et;
    logic [2:0]  eb;
  } vec_t;

  vec_t vt [9];

  initial begin
    int n;
    int t;
    logic pp;

    vt[0] = '{0, 24'h7F7F7F, 24'h808080, 3'b000, 3'b111};
    vt[1] = '{1, 24'h800000, 24'h7F0000, 3'b100, 3'b000};
    vt[2] = '{2, 24'h008000, 24'h007F00, 3'b010, 3'b000};
    vt[3] = '{3, 24'h000080, 24'h00007F, 3'b001, 3'b000};
    vt[4] = '{4, 24'h7F0000, 24'h800000, 3'b000, 3'b100};
    vt[5] = '{5, 24'h007F00, 24'h008000, 3'b000, 3'b010};
    vt[6] = '{6, 24'h00007F, 24'h000080, 3'b000, 3'b001};
    vt[7] = '{7, 24'hFF0080, 24'h00FF7F, 3'b101, 3'b010};
    vt[8] = '{8, 24'h000000, 24'hFFFFFF, 3'b000, 3'b111};

    rst = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 24'hFFFFFF;

    // reset state
    step();
    step();
    check("rst_oe_n", oe_n, 1);
    check("rst_lat", lat, 0);
    check("rst_pclk", panel_clk, 0);
    check("rst_row_sel", row_sel, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
    check("rst_addr_top", fb_if.addr_top, 0);
    check("rst_addr_bottom", fb_if.addr_bottom, 0);

    // all-white line timing
    rst = 1'b0;
    enable = 1'b1;
    n = 0;
    t = 0;
    pp = 0;
    while (!lat && t < 600) begin
      step();
      if (panel_clk && !pp) n++;
      pp = panel_clk;
      t++;
    end
    check("t1_pclk_edges", n, 64);
    check("t1_row0_ones", {sav_t[0][0], sav_b[0][63]}, 6'h3F);
    n = 0;
    while (lat && n < 10) begin
      n++;
      step();
    end
    check("t1_lat_cycles", n, 2);
    n = 0;
    while (!oe_n && n < 1000) begin
      n++;
      step();
    end
    check("t1_oe_low_cycles", n, 256);
    wait_latch(1, 800);
    check("t1_line_period", lat_cyc - prev_lat_cyc, 514);

    // index pattern plus threshold table on line 0
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 24'(i);
    foreach (vt[i]) begin
      mem[vt[i].col] = vt[i].pt;
      mem[2048 + vt[i].col] = vt[i].pb;
    end
    step();
    rst = 1'b0;
    wait_latch(0, 800);
    foreach (vt[i]) begin
      check($sformatf("thr_top_c%0d", vt[i].col),
            sav_t[0][vt[i].col], vt[i].et);
      check($sformatf("thr_bot_c%0d", vt[i].col),
            sav_b[0][vt[i].col], vt[i].eb);
    end
    wait_latch(3, 2000);
    check("t2_line3_col5_top", sav_t[3][5], 3'b001);
    check("t2_line3_col5_bot", sav_b[3][5], 3'b001);

    // random image, two full frames
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 24'($urandom);
    step();
    rst = 1'b0;
    t = 0;
    while (nfd < 2 && t < 40000) begin
      step();
      t++;
    end
    check("t4_frames_done", nfd, 2);
    check("t4_rowsel_stable_oe", oe_viol, 0);

    // drop enable during line 7 shift
    wait_latch(6, 5000);
    repeat (300) step();
    enable = 1'b0;
    wait_latch(7, 600);
    t = 0;
    while (oe_n && t < 20) begin
      step();
      t++;
    end
    t = 0;
    while (!oe_n && t < 400) begin
      step();
      t++;
    end
    check("t5_display_end", oe_n, 1);
    n = 0;
    t = nlat;
    repeat (64 + $urandom_range(0, 63)) begin
      step();
      if (panel_clk || lat || !oe_n) n++;
    end
    check("t5_idle_quiet", n, 0);
    check("t5_idle_no_latch", nlat, t);
    enable = 1'b1;
    wait_latch(8, 800);
    check("t5_resume_row_sel", row_sel, 8);

    // async reset in mid display
    repeat (100) step();
    check("t6_in_display", oe_n, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_oe_n", oe_n, 1);
    check("t6_async_lat", lat, 0);
    check("t6_async_pclk", panel_clk, 0);
    check("t6_async_row_sel", row_sel, 0);
    step();
    step();
    rst = 1'b0;
    wait_latch(0, 800);
    check("t6_restart_row_sel", row_sel, 0);
    check("rowsel_stable_oe_all", oe_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
